uart_rx_oversample: RTL and testbench

//  Serial receive front end of the UART path: synchronises rxd, detects start bits, and recovers
//  8N1 frames using 3-point majority voting at each bit centre.

---
 rtl/uart_rx_oversample_pkg.sv | 18 +
 rtl/uart_rx_oversample_if.sv | 11 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx_oversample.sv | 145 ++++++++++++++
 tb/tb_uart_rx_oversample.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_oversample_pkg.sv
// Shared constants, state encoding and vote helper for the oversampling UART receiver.
package uart_rx_oversample_pkg;

  localparam int unsigned DEFAULT_BAUD = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } urx_state_e;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receive-side bundle: raw serial line in, byte strobe / framing error / busy out.
interface uart_rx_oversample_if;
  logic       rxd;
  logic       valid;
  logic [7:0] data;
  logic       frame_err;
  logic       busy;

  modport master (input rxd, output valid, data, frame_err, busy);
  modport slave  (output rxd, input valid, data, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial line; resets to 1.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: start detect, 3-point majority vote at each bit centre, framing check.
module uart_rx_oversample
  import uart_rx_oversample_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEFAULT_BAUD,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_oversample_if.master  rx
);

  localparam int unsigned CntW = $clog2(CLK_PER_BIT);
  localparam int unsigned Half = CLK_PER_BIT / 2;
  localparam logic [CntW-1:0] CntVote0   = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntVote1   = CntW'(Half);
  localparam logic [CntW-1:0] CntResolve = CntW'(Half + 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(CLK_PER_BIT - 1);

  logic rs;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx.rxd),
    .q  (rs)
  );

  urx_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      vote_q, vote_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            bit_val, mid, wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      vote_q      <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      vote_q      <= vote_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    vote_d      = vote_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    mid     = (cnt_q == CntResolve);
    wrap    = (cnt_q == CntLast);
    cnt_inc = wrap ? '0 : cnt_q + CntW'(1);
    // Third vote point is the live sample, so the bit resolves in the cnt = H+1 cycle.
    bit_val = majority3({rs, vote_q});

    if (state_q != StIdle) begin
      if (cnt_q == CntVote0) vote_d[0] = rs;
      if (cnt_q == CntVote1) vote_d[1] = rs;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rs) state_d = StStart;
      end
      StStart: begin
        cnt_d = cnt_inc;
        if (mid && bit_val) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        cnt_d = cnt_inc;
        if (mid) shreg_d = {bit_val, shreg_q[7:1]};
        if (wrap) begin
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop: begin
        cnt_d = cnt_inc;
        // Leave at mid-stop so a start bit right after the stop bit is not missed.
        if (mid) begin
          cnt_d = '0;
          if (bit_val) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // cnt counts consecutive high samples; H+1 of them end the break.
        if (!rs) begin
          cnt_d = '0;
        end else if (cnt_q == CntVote1) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx.valid     = valid_q;
  assign rx.data      = data_q;
  assign rx.frame_err = frame_err_q;
  assign rx.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench: frames pushed as expected events, an independent monitor pops and compares.
module tb_uart_rx_oversample;

  localparam int C = 16;
  localparam int H = C / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_oversample_if rx_if ();

  uart_rx_oversample #(
    .CLK_PER_BIT(C),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
    logic       chk_lat;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] model_data = 8'h00;
  logic       mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT strobes an output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rx_if.valid || rx_if.frame_err) begin
        check("valid_err_exclusive", {31'b0, rx_if.valid & rx_if.frame_err}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: valid=%0b frame_err=%0b data=%0h, nothing expected",
                   rx_if.valid, rx_if.frame_err, rx_if.data);
        end else begin
          mon_e = sb.pop_front();
          check("event_kind_frame_err", {31'b0, rx_if.frame_err}, {31'b0, mon_e.err});
          if (!mon_e.err) begin
            check("rx_data", {24'b0, rx_if.data}, {24'b0, mon_e.data});
            model_data = mon_e.data;
            if (mon_e.chk_lat) check("latency", 32'(cyc - fall_cyc), 32'd157);
          end else begin
            check("data_held_on_err", {24'b0, rx_if.data}, {24'b0, model_data});
          end
        end
      end else begin
        check("data_held", {24'b0, rx_if.data}, {24'b0, model_data});
      end
    end
  end

  // Waveform of one frame with optional edge jitter (non-cumulative) and mid-bit glitches.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit jit,
                            input bit glitch, input int cut, input bit lat);
    int   e[11];
    int   total;
    int   k;
    logic [9:0] bits;
    logic lvl;
    exp_t x;
    bits = {stop, b, 1'b0};
    e[0] = 0;
    for (int i = 1; i <= 10; i++) e[i] = i * C + (jit ? int'($urandom_range(6)) - 3 : 0);
    total = (cut >= 0) ? cut : e[10];
    if (cut < 0) begin
      x.err = ~stop;
      x.data = b;
      x.chk_lat = lat;
      sb.push_back(x);
    end
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      k = 0;
      while (k < 9 && t >= e[k+1]) k++;
      lvl = bits[k];
      if (glitch && t == k * C + H) lvl = ~lvl;
      rx_if.rxd = lvl;
      if (t == 0) fall_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_if.rxd = 1'b1;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"},     {31'b0, rx_if.valid},     32'd0);
    check({tag, "_frame_err"}, {31'b0, rx_if.frame_err}, 32'd0);
    check({tag, "_busy"},      {31'b0, rx_if.busy},      32'd0);
    check({tag, "_data"},      {24'b0, rx_if.data},      32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    rx_if.rxd = 1'b1;
    model_data = 8'h00;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("in_reset");
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("after_reset");
  endtask

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    finish_test();
  end

  initial begin
    bit busy_seen;
    bit busy_cleared;
    logic [7:0] rb;
    logic       rstop;
    rx_if.rxd = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset");
    mon_en = 1'b1;
    idle(10);

    // 1: single frame with latency check
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    idle(30);

    // 2: back-to-back frames, no idle bits
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    idle(30);

    // 3: short low pulse must be rejected as a glitch
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_if.rxd = 1'b0;
    end
    busy_seen = 1'b0;
    busy_cleared = 1'b0;
    for (int i = 0; i < 60 && !busy_cleared; i++) begin
      @(negedge clk);
      rx_if.rxd = 1'b1;
      if (rx_if.busy) busy_seen = 1'b1;
      else if (busy_seen) busy_cleared = 1'b1;
    end
    check("glitch_busy_seen", {31'b0, busy_seen}, 32'd1);
    check("glitch_busy_cleared", {31'b0, busy_cleared}, 32'd1);
    idle(10);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    idle(30);

    // 4: framing error, long break, then recovery
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rx_if.rxd = 1'b0;
    end
    idle(30);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    idle(30);

    // 5: jitter plus mid-bit glitches
    send_frame(8'h96, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    idle(30);

    // 6: reset mid-frame at data bit 4
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 5 * C + H, 1'b0);
    do_reset();
    idle(20);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1, 1'b1);
    idle(30);

    // Randomised frames: bytes, stop errors, jitter, glitches and gaps
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rstop = ($urandom_range(4) != 0);
      send_frame(rb, rstop, 1'($urandom_range(1)), 1'($urandom_range(1)), -1, 1'b0);
      idle(rstop ? int'($urandom_range(20)) : 20 + int'($urandom_range(10)));
    end

    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    idle(5);
    finish_test();
  end

endmodule
